// File: rtl/sum_feed.sv
// Operand feeder for the pipelined adder: buffers producer pairs in a small FIFO,
// issues one pair per cycle and tracks when the adder output becomes valid.
module sum_feed #(
    parameter int W        = 4,
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_A,
    input  logic [W-1:0]              in_B,
    input  logic                      hold,
    output logic [W-1:0]              data_A,
    output logic [W-1:0]              data_B,
    output logic                      data_valid,
    output logic                      sum_valid,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]        mem_a_q [DEPTH];
    logic [W-1:0]        mem_b_q [DEPTH];

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [W-1:0]        data_a_q, data_a_d;
    logic [W-1:0]        data_b_q, data_b_d;
    logic                data_valid_q, data_valid_d;
    logic [PIPE_LAT-1:0] vld_dly_q, vld_dly_d;

    logic push;
    logic pop;

    // Ready depends on occupancy alone so the producer never sees a loop through in_valid.
    always_comb begin
        in_ready = (count_q != FULL);
        push     = in_valid & in_ready;
        pop      = (count_q != '0) & ~hold;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        data_valid_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            data_a_d     = mem_a_q[rd_ptr_q];
            data_b_d     = mem_b_q[rd_ptr_q];
            data_valid_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Valid delay line mirrors the adder latency so sum_valid lands with its sum.
    always_comb begin
        vld_dly_d    = vld_dly_q;
        vld_dly_d[0] = data_valid_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_dly_d[i] = vld_dly_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            data_valid_q <= 1'b0;
            vld_dly_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            data_valid_q <= data_valid_d;
            vld_dly_q    <= vld_dly_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_A;
            mem_b_q[wr_ptr_q] <= in_B;
        end
    end

    assign data_A     = data_a_q;
    assign data_B     = data_b_q;
    assign data_valid = data_valid_q;
    assign sum_valid  = vld_dly_q[PIPE_LAT-1];
    assign fifo_count = count_q;

endmodule

// File: tb/tb_sum_feed.sv
// Bench for sum_feed: queue-based reference model with a per-cycle compare,
// a stand-in adder pipeline, and directed scenarios with literal expectations.
module tb_sum_feed;

    localparam int W        = 4;
    localparam int DEPTH    = 4;
    localparam int PIPE_LAT = 3;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_A = '0;
    logic [W-1:0]  in_B = '0;
    logic          hold = 1'b0;
    logic [W-1:0]  data_A;
    logic [W-1:0]  data_B;
    logic          data_valid;
    logic          sum_valid;
    logic [CW-1:0] fifo_count;

    sum_feed #(.W(W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_A       (in_A),
        .in_B       (in_B),
        .hold       (hold),
        .data_A     (data_A),
        .data_B     (data_B),
        .data_valid (data_valid),
        .sum_valid  (sum_valid),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream 3-stage adder
    logic [W-1:0] s0, s1, sum_30_dd;
    always @(posedge clk) begin
        s0        <= data_A + data_B;
        s1        <= s0;
        sum_30_dd <= s1;
    end

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending pairs plus a timeline of when sums are due.
    logic [2*W-1:0] mq[$];
    logic [W-1:0]   m_a = '0;
    logic [W-1:0]   m_b = '0;
    bit             m_dv = 1'b0;
    int             cyc = 0;
    bit             sv_at [8192];
    logic [W-1:0]   sum_at [8192];

    task model_clear;
        mq.delete();
        m_a  = '0;
        m_b  = '0;
        m_dv = 1'b0;
        for (int i = cyc; i < cyc + PIPE_LAT + 2; i++) sv_at[i] = 1'b0;
    endtask

    always @(negedge reset_L) model_clear();

    always @(posedge clk) begin
        bit pu, po;
        logic [2*W-1:0] pair;
        cyc++;
        if (!reset_L) begin
            model_clear();
        end else begin
            pu = in_valid && (mq.size() < DEPTH);
            po = (mq.size() != 0) && !hold;
            if (po) begin
                pair = mq.pop_front();
                m_a  = pair[2*W-1:W];
                m_b  = pair[W-1:0];
                m_dv = 1'b1;
                sv_at[cyc + PIPE_LAT]  = 1'b1;
                sum_at[cyc + PIPE_LAT] = m_a + m_b;
            end else begin
                m_dv = 1'b0;
            end
            if (pu) mq.push_back({in_A, in_B});
        end
    end

    logic [W-1:0] sum_log[$];
    int           dv_cnt = 0;

    always @(negedge clk) begin
        chk("fifo_count", fifo_count, mq.size());
        chk("in_ready", in_ready, int'(mq.size() != DEPTH));
        chk("data_valid", data_valid, m_dv);
        chk("data_A", data_A, m_a);
        chk("data_B", data_B, m_b);
        chk("sum_valid", sum_valid, sv_at[cyc]);
        if (sum_valid) begin
            chk("sum", sum_30_dd, sum_at[cyc]);
            sum_log.push_back(sum_30_dd);
        end
        if (data_valid) dv_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_A = a;
        in_B = b;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        hold = 1'b0;
        repeat (DEPTH + PIPE_LAT + 3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        step();
        step();
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_data_A", data_A, 0);
        reset_L = 1'b1;

        // T1: single pair, latency
        in_valid = 1'b1; in_A = 4'd3; in_B = 4'd5;
        step();
        in_valid = 1'b0;
        chk("t1_count_after_push", fifo_count, 1);
        step();
        chk("t1_data_A", data_A, 3);
        chk("t1_data_B", data_B, 5);
        chk("t1_data_valid", data_valid, 1);
        step();
        step();
        chk("t1_sum_valid_early", sum_valid, 0);
        step();
        chk("t1_sum_valid", sum_valid, 1);
        chk("t1_sum", sum_30_dd, 8);
        drain();

        // T2: fill under hold, fifth pair waits
        sum_log.delete();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(W'(i + 1), W'(i + 2));
        chk("t2_full_count", fifo_count, 4);
        chk("t2_full_ready", in_ready, 0);
        in_valid = 1'b1; in_A = 4'd9; in_B = 4'd9;
        step();
        chk("t2_fifth_held", fifo_count, 4);
        hold = 1'b0;
        step();
        chk("t2_first_out_A", data_A, 1);
        chk("t2_first_out_dv", data_valid, 1);
        push_pair(4'd9, 4'd9);
        drain();
        chk("t2_sum_count", sum_log.size(), 5);
        chk("t2_first_sum", sum_log[0], 3);
        chk("t2_last_sum", sum_log[4], 2);

        // T3: ten pairs, pointer wrap
        sum_log.delete();
        for (int i = 0; i < 10; i++) push_pair(W'(i), W'(i + 1));
        drain();
        chk("t3_sum_count", sum_log.size(), 10);
        chk("t3_first_sum", sum_log[0], 1);
        chk("t3_mid_sum", sum_log[5], 11);
        chk("t3_last_sum", sum_log[9], 3);

        // T4: hold toggling with six pairs
        dv_cnt = 0;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(W'(10 + i), W'(i));
        idx = 4;
        for (int k = 0; k < 16; k++) begin
            hold = k[0];
            if (idx < 6 && in_ready) begin
                in_valid = 1'b1;
                in_A = W'(10 + idx);
                in_B = W'(idx);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("t4_issued", dv_cnt, 6);

        // T5: reset mid-stream
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(W'(i + 2), W'(i + 7));
        hold = 1'b0;
        step();
        step();
        hold = 1'b1;
        push_pair(4'd1, 4'd1);
        chk("t5_buffered", fifo_count, 3);
        reset_L = 1'b0;
        #1;
        chk("t5_imm_count", fifo_count, 0);
        chk("t5_imm_dv", data_valid, 0);
        chk("t5_imm_sv", sum_valid, 0);
        chk("t5_imm_A", data_A, 0);
        chk("t5_imm_B", data_B, 0);
        chk("t5_imm_ready", in_ready, 1);
        sum_log.delete();
        dv_cnt = 0;
        hold = 1'b0;
        step();
        step();
        reset_L = 1'b1;
        repeat (8) step();
        chk("t5_no_sum_after", sum_log.size(), 0);
        chk("t5_no_issue_after", dv_cnt, 0);

        // T6: wrap sum and simultaneous push/pop
        sum_log.delete();
        push_pair(4'hF, 4'hF);
        drain();
        chk("t6_sum_count", sum_log.size(), 1);
        chk("t6_wrap_sum", sum_log[0], 14);
        hold = 1'b1;
        push_pair(4'd1, 4'd2);
        push_pair(4'd3, 4'd4);
        chk("t6_count_two", fifo_count, 2);
        hold = 1'b0;
        push_pair(4'd5, 4'd6);
        chk("t6_pushpop_count", fifo_count, 2);
        chk("t6_pushpop_A", data_A, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
